// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache (4-word lines) in front of a req/ack word memory.
// Latency: load hit is combinational (0 stall); miss stalls 1 + refill beats; store stalls until mem_ack.
// Backpressure: stall holds the CPU request stable; mem_req is held with stable addr/data/strb until mem_ack.
//
// Ports: clk, rst_n (async, active-low); CPU side RE, WE, A, WD, AddressingControl (funct3) -> RD, stall;
//        memory side mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb <- mem_rdata, mem_ack.
// Optional: define DCACHE_STATS_EN to add 32-bit hit_count / miss_count outputs.
module dcache_direct #(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 17,
  parameter int LINES         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RE,
  input  logic            WE,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] WD,
  input  logic [2:0]      AddressingControl,
  output logic [XLEN-1:0] RD,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDRESS_WIDTH - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state_q, state_d;

  // Line storage
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [XLEN-1:0]  data_q [LINES][4];

  // Refill / write-through context
  logic [1:0]               cnt_q,   cnt_d;
  logic [ADDRESS_WIDTH-1:4] base_q,  base_d;
  logic [ADDRESS_WIDTH-1:2] waddr_q, waddr_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic                     whit_q,  whit_d;
  // Set for the IDLE cycle right after a refill, so the replayed load is not counted as a hit
  logic                     post_refill_q, post_refill_d;

  logic            stall_c;
  logic [XLEN-1:0] rd_c;
  logic            refill_wr, set_valid, merge_wr;
  logic            hit_inc, miss_inc;

  // Lookup of the current CPU address
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [1:0]       lk_word;
  logic             lk_hit;
  logic [XLEN-1:0]  lk_dat;

  assign lk_idx  = A[3+IDX_W:4];
  assign lk_tag  = A[ADDRESS_WIDTH-1:4+IDX_W];
  assign lk_word = A[3:2];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_dat  = data_q[lk_idx][lk_word];

  // Upper address bits beyond ADDRESS_WIDTH are deliberately ignored
  logic unused_a;
  assign unused_a = ^A[XLEN-1:ADDRESS_WIDTH];

  // Refill and write targets
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_word;

  assign r_idx  = base_q[3+IDX_W:4];
  assign r_tag  = base_q[ADDRESS_WIDTH-1:4+IDX_W];
  assign w_idx  = waddr_q[3+IDX_W:4];
  assign w_word = waddr_q[3:2];

  // Load extraction
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_dat;

  always_comb begin
    ld_byte = lk_dat[{A[1:0], 3'b000} +: 8];
    ld_half = A[1] ? lk_dat[31:16] : lk_dat[15:0];
    ld_dat  = '0;
    case (AddressingControl)
      3'b000:  ld_dat = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_dat = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b010:  ld_dat = lk_dat;
      3'b100:  ld_dat = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_dat = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_dat = '0;
    endcase
  end

  // Store lane alignment: data is moved to its byte lanes with zeros elsewhere
  logic            st_ok;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_dat;

  always_comb begin
    st_ok   = 1'b0;
    st_strb = 4'b0000;
    st_dat  = '0;
    case (AddressingControl)
      3'b000: begin
        st_ok   = 1'b1;
        st_strb = 4'b0001 << A[1:0];
        st_dat  = XLEN'(WD[7:0]) << {A[1:0], 3'b000};
      end
      3'b001: begin
        st_ok   = 1'b1;
        st_strb = A[1] ? 4'b1100 : 4'b0011;
        st_dat  = A[1] ? {WD[15:0], 16'h0000} : {16'h0000, WD[15:0]};
      end
      3'b010: begin
        st_ok   = 1'b1;
        st_strb = 4'b1111;
        st_dat  = WD;
      end
      default: ;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    whit_d        = whit_q;
    stall_c       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_wstrb     = 4'b0000;
    rd_c          = '0;
    refill_wr     = 1'b0;
    set_valid     = 1'b0;
    merge_wr      = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (WE) begin
          if (st_ok) begin
            stall_c = 1'b1;
            waddr_d = A[ADDRESS_WIDTH-1:2];
            wdata_d = st_dat;
            wstrb_d = st_strb;
            whit_d  = lk_hit;
            state_d = WRITE;
          end
        end else if (RE) begin
          if (lk_hit) begin
            rd_c    = ld_dat;
            hit_inc = !post_refill_q;
          end else begin
            stall_c  = 1'b1;
            base_d   = A[ADDRESS_WIDTH-1:4];
            cnt_d    = 2'd0;
            miss_inc = 1'b1;
            state_d  = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        stall_c = 1'b1;
        if (mem_ack) begin
          refill_wr = 1'b1;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            set_valid = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wstrb = wstrb_q;
        // The CPU retires the store in the ack cycle
        stall_c   = !mem_ack;
        if (mem_ack) begin
          merge_wr = whit_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign post_refill_d = (state_q == REFILL) && (state_d == IDLE);

  // Gate with reset so stall is low while reset is held, whatever RE does
  assign stall     = stall_c & rst_n;
  assign RD        = rd_c;
  assign mem_addr  = (state_q == REFILL) ? XLEN'({base_q, cnt_q, 2'b00})
                                         : XLEN'({waddr_q, 2'b00});
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      base_q        <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      wstrb_q       <= 4'b0000;
      whit_q        <= 1'b0;
      post_refill_q <= 1'b0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      whit_q        <= whit_d;
      post_refill_q <= post_refill_d;
      // Valid only rises after the last beat, so a partial line is never visible
      if (set_valid) begin
        valid_q[r_idx] <= 1'b1;
      end
    end
  end

  // Data and tag arrays need no reset: valid bits guard them
  always_ff @(posedge clk) begin
    if (refill_wr) begin
      data_q[r_idx][cnt_q] <= mem_rdata;
    end
    if (merge_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          data_q[w_idx][w_word][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
    if (set_valid) begin
      tag_q[r_idx] <= r_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_inc) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_inc) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
module tb_dcache_direct;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        RE    = 1'b0;
  logic        WE    = 1'b0;
  logic [31:0] A     = '0;
  logic [31:0] WD    = '0;
  logic [2:0]  AC    = '0;
  logic [31:0] RD;
  logic        stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_direct dut (
    .clk(clk), .rst_n(rst_n), .RE(RE), .WE(WE), .A(A), .WD(WD),
    .AddressingControl(AC), .RD(RD), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- backing memory model ----------------
  logic [31:0] mem [0:32767];
  int lat  = 1;   // ack arrives in the lat-th cycle of each beat
  int wcnt = 0;

  assign mem_ack   = mem_req && (wcnt >= lat - 1);
  assign mem_rdata = mem[mem_addr[16:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } acc_t;
  acc_t acc_q[$];

  logic        hold_q = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_strb;

  always @(negedge clk) begin
    if (mem_req && hold_q) begin
      chk("hold mem_addr", mem_addr, prev_addr);
      chk("hold mem_wdata", mem_wdata, prev_wdata);
      chk("hold mem_wstrb", {28'd0, mem_wstrb}, {28'd0, prev_strb});
    end
    hold_q     = mem_req && !mem_ack;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_strb  = mem_wstrb;
    if (mem_req && mem_ack) begin
      acc_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata, strb: mem_wstrb});
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[16:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          st;     // expected stall cycles
    int          nr;     // expected memory reads
    int          nw;     // expected memory writes
    logic [31:0] maddr;  // first memory address
    logic [31:0] mwd;
    logic [3:0]  strb;
  } vec_t;

  function automatic vec_t mk(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] exp_rd, int st, int nr, int nw,
                              logic [31:0] maddr, logic [31:0] mwd, logic [3:0] strb);
    vec_t v;
    v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.exp_rd = exp_rd;
    v.st = st; v.nr = nr; v.nw = nw; v.maddr = maddr; v.mwd = mwd; v.strb = strb;
    return v;
  endfunction

  logic [31:0] exp_q[$];

  // Called at posedge+1; returns at posedge+1 after the request retires.
  task automatic run_op(input string id, input vec_t v);
    int n0, st, nr, nw;
    logic [31:0] got;
    n0 = acc_q.size();
    RE = !v.we; WE = v.we; A = v.a; WD = v.wd; AC = v.f3;
    if (!v.we) exp_q.push_back(v.exp_rd);
    st = 0;
    @(negedge clk);
    while (stall === 1'b1 && st < 100) begin
      st++;
      @(negedge clk);
    end
    if (st >= 100) begin
      checks++; failures++;
      $display("FAIL %s timeout: stall still high after %0d cycles, required release", id, st);
    end
    got = RD;
    if (!v.we) chk({id, " RD"}, got, exp_q.pop_front());
    chk({id, " stall cycles"}, st, v.st);
    @(posedge clk);
    #1;
    RE = 1'b0; WE = 1'b0;
    nr = 0; nw = 0;
    for (int k = n0; k < acc_q.size(); k++) begin
      if (acc_q[k].we) begin
        nw++;
        chk({id, " waddr"}, acc_q[k].addr, v.maddr);
        chk({id, " wdata"}, acc_q[k].wdata, v.mwd);
        chk({id, " wstrb"}, {28'd0, acc_q[k].strb}, {28'd0, v.strb});
      end else begin
        chk({id, " raddr"}, acc_q[k].addr, v.maddr + 32'(4 * nr));
        nr++;
      end
    end
    chk({id, " reads"}, nr, v.nr);
    chk({id, " writes"}, nw, v.nw);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int n0, k;

    for (int i = 0; i < 32768; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
    mem[32'h100 >> 2] = 32'hDEADBEEF;

    //                 we f3      addr      wd            exp_rd        st nr nw maddr     mwd           strb
    tbl.push_back(mk(0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 5, 4, 0, 32'h100,  32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b010, 32'h104,  32'h0,        32'h10000104, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b000, 32'h103,  32'h0,        32'hFFFFFFDE, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b100, 32'h103,  32'h0,        32'h000000DE, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b001, 32'h102,  32'h0,        32'hFFFFDEAD, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b101, 32'h102,  32'h0,        32'h0000DEAD, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b000, 32'h100,  32'h0,        32'hFFFFFFEF, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(1, 3'b000, 32'h101,  32'hFFFFFF55, 32'h0,        1, 0, 1, 32'h100,  32'h00005500, 4'b0010));
    tbl.push_back(mk(0, 3'b010, 32'h100,  32'h0,        32'hDEAD55EF, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(1, 3'b010, 32'h2000, 32'h12345678, 32'h0,        1, 0, 1, 32'h2000, 32'h12345678, 4'b1111));
    tbl.push_back(mk(0, 3'b010, 32'h2000, 32'h0,        32'h12345678, 5, 4, 0, 32'h2000, 32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b010, 32'h200,  32'h0,        32'h10000200, 5, 4, 0, 32'h200,  32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b010, 32'h100,  32'h0,        32'hDEAD55EF, 5, 4, 0, 32'h100,  32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b010, 32'h200,  32'h0,        32'h10000200, 5, 4, 0, 32'h200,  32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b010, 32'h100,  32'h0,        32'hDEAD55EF, 5, 4, 0, 32'h100,  32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b001, 32'h10E,  32'h0,        32'h00001000, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b011, 32'h100,  32'h0,        32'h00000000, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(1, 3'b011, 32'h104,  32'hFFFFFFFF, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(1, 3'b001, 32'h106,  32'h1234ABCD, 32'h0,        1, 0, 1, 32'h104,  32'hABCD0000, 4'b1100));
    tbl.push_back(mk(0, 3'b010, 32'h104,  32'h0,        32'hABCD0104, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b000, 32'h107,  32'h0,        32'hFFFFFFAB, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b101, 32'h106,  32'h0,        32'h0000ABCD, 0, 0, 0, 32'h0,    32'h0,        4'b0000));
    tbl.push_back(mk(0, 3'b010, 32'h150,  32'h0,        32'h10000150, 5, 4, 0, 32'h150,  32'h0,        4'b0000));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("reset RD", RD, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_op($sformatf("v%0d", i), tbl[i]);

    // Delayed ack: 3 cycles per beat, conflicting lines
    lat = 3;
    run_op("lat3 ld200", mk(0, 3'b010, 32'h200, 32'h0, 32'h10000200, 13, 4, 0, 32'h200, 32'h0, 4'b0000));
    run_op("lat3 ld100", mk(0, 3'b010, 32'h100, 32'h0, 32'hDEAD55EF, 13, 4, 0, 32'h100, 32'h0, 4'b0000));
    run_op("lat3 sw400", mk(1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 3, 0, 1, 32'h400, 32'hCAFEF00D, 4'b1111));
    lat = 1;

    // Reset in the middle of a refill
    n0 = acc_q.size();
    RE = 1'b1; A = 32'h400; AC = 3'b010;
    k = 0;
    while (acc_q.size() - n0 < 2 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midreset acks", acc_q.size() - n0, 32'd2);
    chk("midreset mem_req", {31'd0, mem_req}, 32'd0);
    chk("midreset stall", {31'd0, stall}, 32'd0);
    RE = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef DCACHE_STATS_EN
    chk("stats hit after reset", hit_count, 32'd0);
    chk("stats miss after reset", miss_count, 32'd0);
`endif
    run_op("post-reset ld400", mk(0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 5, 4, 0, 32'h400, 32'h0, 4'b0000));
`ifdef DCACHE_STATS_EN
    chk("stats hit after refill", hit_count, 32'd0);
    chk("stats miss after refill", miss_count, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-through, no-write-allocate data cache between the memory-stage load/store path and the word-wide backing data memory. It accepts byte/halfword/word loads and stores qualified by funct3, returns sign- or zero-extended load data on hits in the same cycle, and raises `stall` while it refills a line or completes a store. The backing memory sits downstream behind a req/ack word port.

## Interface
- `XLEN`, default 32: data width; only 32 is supported.
- `ADDRESS_WIDTH`, default 17: byte-address bits used; upper address bits are ignored.
- `LINES`, default 16: number of cache lines; must be a power of two, at least 2.
- Line size is fixed at 4 words (16 B).
  - Index is `A[3+log2(LINES):4]`.
  - Tag is `A[ADDRESS_WIDTH-1:4+log2(LINES)]`.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `RE`, input, 1: load request.
- `WE`, input, 1: store request; has priority if asserted together with `RE`.
- `A`, input, XLEN: byte address.
- `WD`, input, XLEN: store data, right-aligned.
- `AddressingControl`, input, 3: funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `RD`, output, XLEN: load data; valid when `RE && !stall`.
- `stall`, output, 1: CPU must hold `RE`/`WE`/`A`/`WD`/`AddressingControl` stable while high.
- `mem_req`, output, 1: memory request; held until `mem_ack`.
- `mem_we`, output, 1: 1 for write, 0 for read.
- `mem_addr`, output, XLEN: word-aligned address; bits [1:0] are always 0.
- `mem_wdata`, output, XLEN: lane-aligned write data.
- `mem_wstrb`, output, 4: byte-lane enables, bit i for byte lane i.
- `mem_rdata`, input, XLEN: read data; valid with `mem_ack`.
- `mem_ack`, input, 1: one-cycle completion pulse. It may arrive in the same cycle `mem_req` rises, or any later cycle.

## Operation
- Storage per line: a valid bit, a tag, and 4×32-bit data words.
- Reset:
  - All valid bits clear and the FSM goes to IDLE.
  - `mem_req`, `mem_we`, `mem_wstrb`, `stall` and `RD` are 0.
  - Reset has immediate effect in any state and abandons any in-flight refill or write.
- Alignment: sub-word accesses are not required to be aligned to their size.
  - LH/LHU/SH use `A[1]` to select the halfword.
  - LB/LBU/SB use `A[1:0]` to select the byte.
  - LW/SW ignore `A[1:0]`.
  - No access ever spans two words.
- Load extraction:
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Any other load funct3 gives `RD` = 0 (still counted as a hit or miss).
- FSM states are IDLE, REFILL and WRITE.
- IDLE:
  - Hit = valid bit set and tag match.
  - `RE` hit: `RD` is driven combinationally from the data array; `stall` = 0.
  - `RE` miss: `stall` = 1; latch the line base address; clear the word counter; go to REFILL.
  - `WE`: `stall` = 1; latch the word address, lane-aligned data, strobes and the hit flag; go to WRITE.
  - Store strobes: SB 0001<<`A[1:0]`, SH 0011<<(2·`A[1]`), SW 1111.
  - Store funct3 outside SB/SH/SW: no memory access; `stall` = 0.
- REFILL:
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = base + 4·cnt; `stall` = 1.
  - On `mem_ack`: write `mem_rdata` into word cnt and increment cnt.
  - On the ack with cnt = 3: set the valid bit and tag, then go to IDLE. The held load then hits.
  - The valid bit stays clear for the whole refill, so a partial line is never visible.
- WRITE:
  - `mem_req` = 1 and `mem_we` = 1, with the latched address, data and strobes.
  - `stall` = !`mem_ack`.
  - On `mem_ack`: if the latched hit flag is set, merge the strobed bytes into the cached word. Then go to IDLE.
  - The CPU advances in the ack cycle, so a store is never issued twice.
  - Store misses do not allocate.

## Timing
- Load hit: 0 stall cycles, combinational `RD`.
- Load miss: stall = 1 + Σ(cycles per refill beat). With same-cycle ack this is 5 cycles (IDLE + 4×REFILL), and data returns in cycle 6.
- Store: stall = 1 + wait cycles for ack. Minimum is 1 stall cycle; the store retires in cycle 2.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are stable for the whole time `mem_req` is high.
- `mem_req` drops in the cycle after ack unless the next refill beat follows. Consecutive refill beats keep `mem_req` high with the address advancing.
- No new CPU request is sampled outside IDLE.

## Configuration
- `DCACHE_STATS_EN` defined: adds the outputs `hit_count` and `miss_count`.
  - Both are 32 bits wide and reset to 0.
  - Each increments once per IDLE-cycle load decision: hit or miss.
  - The post-refill hit is not counted.
  - Both wrap at 2^32.
- Not defined: these ports and counters do not exist.

## Test plan
- Load miss then hit (same-cycle ack, memory word 0x100 = 0xDEADBEEF):
  - After reset, LW 0x100 gives 4 reads at 0x100/0x104/0x108/0x10C, 5 stall cycles, then `RD` = 0xDEADBEEF.
  - LW 0x104 immediately after: `stall` = 0, no `mem_req`.
- Extraction on the cached word 0xDEADBEEF:
  - LB 0x103 → 0xFFFFFFDE; LBU 0x103 → 0x000000DE.
  - LH 0x102 → 0xFFFFDEAD; LHU 0x102 → 0x0000DEAD.
  - LB 0x100 → 0xFFFFFFEF.
- Store hit:
  - SB 0x101 with `WD` = 0x55 gives a write at 0x100, `mem_wstrb` = 0010, `mem_wdata` = 0x00005500.
  - A following LW 0x100 hits with 0xDEAD55EF.
- Store miss:
  - SW 0x2000 with 0x12345678 gives exactly one write and no refill.
  - A following LW 0x2000 misses and refetches.
- Index conflict (LINES = 16):
  - Alternating LW 0x100 and LW 0x200 (both index 0) misses on every access.
  - Repeat with `mem_ack` delayed 3 cycles: each beat holds its address and the miss stalls 13 cycles.
- Reset mid-refill:
  - Assert `rst_n` = 0 after 2 refill acks: `mem_req` falls immediately.
  - After reset, LW to the same address misses and all 4 words are fetched again.
  - With `DCACHE_STATS_EN`, both counters read 0.
